// File: rtl/engine_busy_ctrl.sv
// engine_busy_ctrl
// Job-handshake controller between the NIOS start/abort PIO outputs and the
// hardware search engine. Drives the busy level polled by firmware, a
// start/ack handshake to the engine, done detection on the asynchronous
// engine flag, a watchdog with forced abort, and a saturating busy-cycle
// counter for profiling.

module engine_busy_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd50000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_req,
    input  logic        abort_req,
    input  logic        eng_ack,
    input  logic        eng_done,
    output logic        eng_start,
    output logic        eng_abort,
    output logic        busy,
    output logic        timeout,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } state_t;

    // The watchdog fires on the edge where the timer holds this value, which
    // is TIMEOUT_CYCLES edges after entering REQ.
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic [31:0]              timer;
    logic                     start_req_d;
    logic                     abort_req_d;
    logic [SYNC_STAGES-1:0]   done_sync;
    logic                     done_last_d;

    logic start_edge;
    logic abort_edge;
    logic done_edge;
    logic watchdog_hit;

    assign start_edge   = start_req & ~start_req_d;
    assign abort_edge   = abort_req & ~abort_req_d;
    assign done_edge    = done_sync[SYNC_STAGES-1] & ~done_last_d;
    assign watchdog_hit = (timer == TIMER_LAST);

    // Delayed copies of the PIO levels; they reset high so a level already
    // asserted when reset releases is not mistaken for a new request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_req_d <= 1'b1;
            abort_req_d <= 1'b1;
        end else begin
            start_req_d <= start_req;
            abort_req_d <= abort_req;
        end
    end

    // Synchronizer for the asynchronous done flag, plus one extra flop on the
    // last stage so a rising edge of the synchronized level can be detected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_sync   <= '0;
            done_last_d <= 1'b0;
        end else begin
            done_sync   <= {done_sync[SYNC_STAGES-2:0], eng_done};
            done_last_d <= done_sync[SYNC_STAGES-1];
        end
    end

    // Job state machine with registered outputs, watchdog timer and the
    // saturating busy-cycle counter (which simply counts edges where busy
    // was already high, so it equals the busy width once the job ends).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
        end else begin
            if (busy && (cycles != 32'hFFFF_FFFF)) begin
                cycles <= cycles + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= REQ;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        cycles    <= '0;
                        timer     <= '0;
                        timeout   <= 1'b0;
                    end
                end

                REQ: begin
                    timer <= timer + 32'd1;
                    if (abort_edge || watchdog_hit) begin
                        state     <= ABORT;
                        eng_abort <= 1'b1;
                        eng_start <= 1'b0;
                        timeout   <= ~abort_edge;
                    end else if (eng_ack) begin
                        state     <= RUN;
                        eng_start <= 1'b0;
                    end
                end

                RUN: begin
                    timer <= timer + 32'd1;
                    if (done_edge) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (abort_edge || watchdog_hit) begin
                        state     <= ABORT;
                        eng_abort <= 1'b1;
                        eng_start <= 1'b0;
                        timeout   <= ~abort_edge;
                    end
                end

                ABORT: begin
                    state     <= IDLE;
                    eng_abort <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
